// File: rtl/a2d_spi_resp.sv
// A2D conversion responder: two 16-bit SPI frames to an ADC128S per request, 12-bit result out.
// Optional build macro A2D_RES_INV_EN inverts the returned result (IR photo-sensor polarity).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; a captured request starts frame 1
// FRM1  | SS_n low, sending channel select, receive data discarded
// GAP   | SS_n high for two clocks between frames
// FRM2  | SS_n low, channel word resent, result shifted in
module a2d_spi_resp #(
  parameter int SCLK_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FRM1 = 2'd1,
    GAP  = 2'd2,
    FRM2 = 2'd3
  } state_t;

  localparam logic [SCLK_W-1:0] CNT_MAX   = {SCLK_W{1'b1}};
  localparam logic [SCLK_W-1:0] RISE_PT   = CNT_MAX >> 1;
  localparam logic [SCLK_W-1:0] CNT_START = CNT_MAX - SCLK_W'(8);

  state_t            state;
  logic [SCLK_W-1:0] cnt;
  logic [SCLK_W-1:0] cnt_inc;
  logic [4:0]        bit_cnt;
  logic [15:0]       tx_reg;
  logic [11:0]       rx_reg;
  logic [2:0]        ch_q;
  logic              req_q;
  logic              gap_q;
  logic              frm_done;
  logic              shift_pt;

  assign cnt_inc  = cnt + 1'b1;
  assign frm_done = (cnt == CNT_MAX) && (bit_cnt == 5'd16);
  // Falling-edge shifts only between the first and last rising edge of the frame.
  assign shift_pt = (cnt == CNT_MAX) && (bit_cnt != 5'd0) && !bit_cnt[4];
  assign MOSI     = tx_reg[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      tx_reg    <= '0;
      rx_reg    <= '0;
      ch_q      <= '0;
      req_q     <= 1'b0;
      gap_q     <= 1'b0;
      SS_n      <= 1'b1;
      SCLK      <= 1'b1;
      cnv_cmplt <= 1'b0;
      res       <= '0;
    end else begin
      // Request and channel are captured together, only while idle; busy requests are dropped.
      req_q <= (state == IDLE) && strt_cnv && !req_q;
      if ((state == IDLE) && strt_cnv && !req_q)
        ch_q <= chnnl;

      case (state)
        IDLE: begin
          if (req_q) begin
            SS_n      <= 1'b0;
            SCLK      <= 1'b1;
            cnt       <= CNT_START;
            bit_cnt   <= '0;
            tx_reg    <= {2'b00, ch_q, 11'h000};
            cnv_cmplt <= 1'b0;
            state     <= FRM1;
          end
        end

        FRM1, FRM2: begin
          if (frm_done) begin
            SS_n  <= 1'b1;
            SCLK  <= 1'b1;
            gap_q <= 1'b0;
            if (state == FRM1) begin
              state <= GAP;
            end else begin
`ifdef A2D_RES_INV_EN
              res <= ~rx_reg;
`else
              res <= rx_reg;
`endif
              cnv_cmplt <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            cnt  <= cnt_inc;
            SCLK <= cnt_inc[SCLK_W-1];
            if (cnt == RISE_PT) begin
              rx_reg  <= {rx_reg[10:0], MISO};
              bit_cnt <= bit_cnt + 5'd1;
            end
            if (shift_pt)
              tx_reg <= {tx_reg[14:0], 1'b0};
          end
        end

        GAP: begin
          if (!gap_q) begin
            gap_q <= 1'b1;
          end else begin
            SS_n    <= 1'b0;
            SCLK    <= 1'b1;
            cnt     <= CNT_START;
            bit_cnt <= '0;
            tx_reg  <= {2'b00, ch_q, 11'h000};
            state   <= FRM2;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: behavioural ADC128S model, scoreboard of expected results and SPI frames.
module tb_a2d_spi_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        strt_cnv = 1'b0;
  logic [2:0]  chnnl = 3'd0;
  logic        MISO = 1'b0;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;

  a2d_spi_resp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .res       (res),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] res;
    longint      t0;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mosi_q[$];
  logic [11:0] adc_mem [8];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;

  function automatic logic [11:0] exp_of(input logic [11:0] v);
`ifdef A2D_RES_INV_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // ADC128S model: drives data on SCLK falls, captures MOSI on rises,
  // returns in each frame the channel addressed by the previous frame.
  logic [2:0]  adc_addr = 3'd0;
  logic [15:0] adc_sr = 16'h0;
  logic [15:0] mosi_sr = 16'h0;
  int          bits = 0;
  int          frame_idx = 0;
  int          sclk_err = 0;
  bit          have_rise = 1'b0;
  time         t_fall = 0;
  time         t_rise = 0;
  time         t_ss_rise = 0;
  logic        ss_prev = 1'b1;
  logic        sclk_prev = 1'b1;

  initial begin
    forever begin
      @(SS_n or SCLK);
      if (SS_n === 1'b0 && ss_prev === 1'b1) begin
        if (frame_idx % 2 == 1)
          chk("gap_clk", longint'(($time - t_ss_rise) / 10), 2);
        adc_sr    = {4'h0, adc_mem[adc_addr]};
        mosi_sr   = 16'h0;
        bits      = 0;
        sclk_err  = 0;
        have_rise = 1'b0;
        t_fall    = $time;
      end
      if (SS_n === 1'b0 && sclk_prev === 1'b1 && SCLK === 1'b0) begin
        MISO   = adc_sr[15];
        adc_sr = {adc_sr[14:0], 1'b0};
        if (have_rise && ($time - t_rise) != 160) sclk_err++;
      end
      if (SS_n === 1'b0 && sclk_prev === 1'b0 && SCLK === 1'b1) begin
        mosi_sr = {mosi_sr[14:0], MOSI};
        bits++;
        if (have_rise && ($time - t_rise) != 320) sclk_err++;
        t_rise    = $time;
        have_rise = 1'b1;
      end
      if (SS_n === 1'b1 && ss_prev === 1'b0) begin
        t_ss_rise = $time;
        if (!rst_n) begin
          frame_idx = 0;
        end else begin
          chk("sclk_rises", bits, 16);
          chk("ss_low_clk", longint'(($time - t_fall) / 10), 521);
          chk("sclk_timing_errs", sclk_err, 0);
          if (mosi_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mosi_frame: got 0x%04h want no frame", mosi_sr);
          end else begin
            chk("mosi_frame", mosi_sr, mosi_q.pop_front());
          end
          adc_addr = mosi_sr[13:11];
          frame_idx++;
        end
      end
      ss_prev   = SS_n;
      sclk_prev = SCLK;
    end
  end

  // Completion monitor: one scoreboard entry per cnv_cmplt rise.
  logic cmplt_prev = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cnv_cmplt && !cmplt_prev) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL cmplt_unexpected: got res 0x%03h want no completion", res);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("res", res, e.res);
          chk("latency", cyc - e.t0, 1045);
        end
      end
      cmplt_prev = cnv_cmplt;
    end
  end

  task automatic issue(input logic [2:0] ch, input bit accept);
    exp_t e;
    @(negedge clk);
    strt_cnv = 1'b1;
    chnnl    = ch;
    @(posedge clk);
    #1;
    if (accept) begin
      e.res = exp_of(adc_mem[ch]);
      e.t0  = cyc;
      exp_q.push_back(e);
      mosi_q.push_back({2'b00, ch, 11'h000});
      mosi_q.push_back({2'b00, ch, 11'h000});
    end
    @(negedge clk);
    strt_cnv = 1'b0;
    chnnl    = 3'($urandom);
  endtask

  task automatic wait_done();
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 1200) begin
      @(posedge clk);
      n++;
    end
    #2;
    total++;
    if (done_cnt == start) begin
      bad++;
      $display("FAIL done_timeout: got no cnv_cmplt want one within 1200 clk");
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_SS_n"}, SS_n, 1);
    chk({tag, "_SCLK"}, SCLK, 1);
    chk({tag, "_MOSI"}, MOSI, 0);
    chk({tag, "_cnv_cmplt"}, cnv_cmplt, 0);
    chk({tag, "_res"}, res, 0);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got no finish want finish before 60000 clk");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] prev;
    int d0;
    logic [2:0] ch;
    for (int i = 0; i < 8; i++) adc_mem[i] = 12'($urandom);
    adc_mem[4] = 12'hA5C;
    adc_mem[2] = 12'h3C1;

    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Channel 4 against a fixed ADC value.
    issue(3'd4, 1'b1);
    wait_done();
    prev = exp_of(12'hA5C);

    // New request while cnv_cmplt is high: flag drops, old result held.
    issue(3'd7, 1'b1);
    @(posedge clk);
    #1;
    chk("cmplt_cleared", cnv_cmplt, 0);
    chk("res_held", res, prev);
    wait_done();

    // Request for channel 2 during frame 1 is ignored.
    adc_mem[4] = 12'($urandom);
    issue(3'd4, 1'b1);
    repeat (100) @(posedge clk);
    issue(3'd2, 1'b0);
    d0 = done_cnt;
    wait_done();
    repeat (50) @(posedge clk);
    chk("one_cmplt", done_cnt - d0, 1);

    // Reset in the middle of frame 2 aborts without completion.
    issue(3'd3, 1'b1);
    repeat (700) @(posedge clk);
    @(negedge clk);
    #2;
    exp_q.delete();
    mosi_q.delete();
    rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(3'd1, 1'b1);
    wait_done();

    for (int k = 0; k < 4; k++) begin
      ch = 3'($urandom_range(0, 7));
      adc_mem[ch] = 12'($urandom);
      issue(ch, 1'b1);
      wait_done();
    end

    repeat (20) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
